// File: rtl/card_dealer.sv
// Card source for the blackjack datapath: deals NUM_CARDS cards per request, one per clock,
// from a Galois LFSR (BASE) or per-mode scripts. Optional shoe tracking with `define DECK_TRACK_EN.
module card_dealer #(
  parameter int          NUM_CARDS = 2,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          CARD_W    = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req,
  input  logic [2:0]                  mode,
  output logic                        busy,
  output logic                        valid,
  output logic [NUM_CARDS*CARD_W-1:0] cards,
  output logic [5:0]                  cards_left
);

  localparam int KW = (NUM_CARDS > 1) ? $clog2(NUM_CARDS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DRAW = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] M_BASE      = 3'd0;
  localparam logic [2:0] M_SIMPLE    = 3'd1;
  localparam logic [2:0] M_DOUBLE    = 3'd2;
  localparam logic [2:0] M_BLACKJACK = 3'd3;
  localparam logic [2:0] M_SPLIT     = 3'd4;

  logic [1:0]                         state;
  logic [2:0]                         mode_q;
  logic [KW-1:0]                      k;
  logic [15:0]                        lfsr, lfsr_nxt;
  logic [2:0]                         ptr_simple, ptr_split;
  logic [1:0]                         ptr_double, ptr_bj;
  logic [NUM_CARDS-1:0][CARD_W-1:0]   card_q;
  logic [3:0]                         rank, wr_val;
  logic                               rank_ok, wr_en, last_card;

`ifdef DECK_TRACK_EN
  logic [2:0] rank_cnt [16];
  logic [5:0] shoe_left;
  assign cards_left = shoe_left;
`else
  assign cards_left = 6'd52;
`endif

  assign cards     = card_q;
  assign last_card = (k == KW'(NUM_CARDS - 1));

  function automatic logic [3:0] simple_card(input logic [2:0] p);
    case (p)
      3'd0:    return 4'd10;
      3'd1:    return 4'd8;
      3'd2:    return 4'd4;
      3'd3:    return 4'd6;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] double_card(input logic [1:0] p);
    case (p)
      2'd0:    return 4'd10;
      2'd1:    return 4'd8;
      default: return 4'd2;
    endcase
  endfunction

  function automatic logic [3:0] bj_card(input logic [1:0] p);
    case (p)
      2'd0:    return 4'd10;
      2'd1:    return 4'd1;
      2'd2:    return 4'd8;
      default: return 4'd9;
    endcase
  endfunction

  function automatic logic [3:0] split_card(input logic [2:0] p);
    case (p)
      3'd0:    return 4'd10;
      3'd1:    return 4'd10;
      3'd2:    return 4'd9;
      3'd3:    return 4'd8;
      3'd4:    return 4'd8;
      3'd5:    return 4'd4;
      3'd6:    return 4'd8;
      default: return 4'd2;
    endcase
  endfunction

  // Candidate rank comes from the current LFSR value; the register steps every BASE draw cycle.
  always_comb begin
    rank     = lfsr[3:0];
    lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    rank_ok  = (rank != 4'd0) && (rank <= 4'd13);
`ifdef DECK_TRACK_EN
    rank_ok  = rank_ok && (rank_cnt[rank] != 3'd0);
`endif
    wr_en  = 1'b1;
    wr_val = 4'd0;
    case (mode_q)
      M_BASE: begin
        wr_en  = rank_ok;
        wr_val = (rank > 4'd10) ? 4'd10 : rank;
      end
      M_SIMPLE:    wr_val = simple_card(ptr_simple);
      M_DOUBLE:    wr_val = double_card(ptr_double);
      M_BLACKJACK: wr_val = bj_card(ptr_bj);
      M_SPLIT:     wr_val = split_card(ptr_split);
      default:     wr_val = 4'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      mode_q     <= M_BASE;
      k          <= '0;
      busy       <= 1'b0;
      valid      <= 1'b0;
      card_q     <= '0;
      lfsr       <= SEED;
      ptr_simple <= '0;
      ptr_double <= '0;
      ptr_bj     <= '0;
      ptr_split  <= '0;
`ifdef DECK_TRACK_EN
      shoe_left  <= 6'd52;
      for (int i = 0; i < 16; i++) rank_cnt[i] <= 3'd4;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            mode_q <= mode;
            card_q <= '0;
            busy   <= 1'b1;
            k      <= '0;
            state  <= S_DRAW;
`ifdef DECK_TRACK_EN
            if (shoe_left < 6'(NUM_CARDS)) begin
              shoe_left <= 6'd52;
              for (int i = 0; i < 16; i++) rank_cnt[i] <= 3'd4;
            end
`endif
          end
        end
        S_DRAW: begin
          if (mode_q == M_BASE) lfsr <= lfsr_nxt;
          if (wr_en) begin
            for (int i = 0; i < NUM_CARDS; i++)
              if (k == KW'(i)) card_q[i] <= CARD_W'(wr_val);
            case (mode_q)
              M_SIMPLE:    ptr_simple <= (ptr_simple == 3'd4) ? 3'd0 : ptr_simple + 3'd1;
              M_DOUBLE:    ptr_double <= (ptr_double == 2'd2) ? 2'd0 : ptr_double + 2'd1;
              M_BLACKJACK: ptr_bj     <= ptr_bj + 2'd1;
              M_SPLIT:     ptr_split  <= ptr_split + 3'd1;
              default:     ;
            endcase
`ifdef DECK_TRACK_EN
            if (mode_q == M_BASE) begin
              rank_cnt[rank] <= rank_cnt[rank] - 3'd1;
              shoe_left      <= shoe_left - 6'd1;
            end
`endif
            if (last_card) begin
              state <= S_DONE;
              busy  <= 1'b0;
              valid <= 1'b1;
            end else begin
              k <= k + KW'(1);
            end
          end
        end
        S_DONE: begin
          valid <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// Scoreboard bench for card_dealer (NUM_CARDS=2): stimulus pushes expected deals, a negedge
// monitor pops and compares cards, accept-to-valid latency and cards_left.
module tb_card_dealer;
  localparam int N = 2;

  logic       clk = 1'b0, reset = 1'b0, req = 1'b0;
  logic [2:0] mode = 3'd0;
  logic       busy, valid;
  logic [7:0] cards;
  logic [5:0] cards_left;

  card_dealer #(.NUM_CARDS(N), .SEED(16'hACE1), .CARD_W(4)) dut (
    .clk(clk), .reset(reset), .req(req), .mode(mode),
    .busy(busy), .valid(valid), .cards(cards), .cards_left(cards_left)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cards;
    int         lat;
    logic [5:0] left;
  } exp_t;

  exp_t       q[$];
  exp_t       e_m;
  logic [3:0] v_m;
  int checks = 0, failures = 0;
  int cyc = 0, acc_cyc = 0;
  logic base_phase = 1'b0;
  int hist[16];
  int bad = 0, tens = 0, base_cards = 0;
  logic [15:0] lf;
  int cnt[16];
  int left_m = 52;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Monitor: latency is counted from the IDLE cycle in which req is sampled.
  always @(negedge clk) begin
    if (!reset) begin
      if (req && !busy && !valid) acc_cyc = cyc;
      if (valid) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid actual cards=%0h expected no deal", cards);
        end else begin
          e_m = q.pop_front();
          chk("cards", cards, e_m.cards);
          chk("latency", cyc - acc_cyc, e_m.lat);
          chk("cards_left", cards_left, e_m.left);
        end
        if (base_phase)
          for (int i = 0; i < N; i++) begin
            v_m = cards[4*i +: 4];
            hist[v_m]++;
            if (v_m == 4'd0 || v_m > 4'd10) bad++;
            if (v_m == 4'd10) tens++;
            base_cards++;
          end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", 1, 0);
  endtask

  task automatic wait_drain();
    int n = 0;
    @(negedge clk);
    while ((q.size() != 0 || busy || valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("drain_timeout", q.size(), 0);
  endtask

  task automatic deal(input logic [2:0] m, input logic push, input logic [7:0] exp_cards, input int lat);
    exp_t e;
    wait_idle();
    if (push) begin
      e.cards = exp_cards;
      e.lat   = lat;
      e.left  = 6'(left_m);
      q.push_back(e);
    end
    mode = m;
    req  = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Golden model of one BASE deal; also advances the model shoe when tracking is enabled.
  task automatic base_deal();
    logic [7:0] cds = 8'h00;
    logic [3:0] r;
    int  lat = 1, n = 0;
    logic ok;
`ifdef DECK_TRACK_EN
    if (left_m < N) begin
      left_m = 52;
      for (int i = 0; i < 16; i++) cnt[i] = 4;
    end
`endif
    while (n < N) begin
      r  = lf[3:0];
      lf = lfsr_step(lf);
      lat++;
      ok = (r >= 4'd1) && (r <= 4'd13);
`ifdef DECK_TRACK_EN
      ok = ok && (cnt[r] > 0);
`endif
      if (ok) begin
        cds[4*n +: 4] = (r > 4'd10) ? 4'd10 : r;
`ifdef DECK_TRACK_EN
        cnt[r]--;
        left_m--;
`endif
        n++;
      end
    end
    deal(3'd0, 1'b1, cds, lat);
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_valid", valid, 0);
    chk("reset_cards", cards, 0);
    chk("reset_cards_left", cards_left, 52);
    reset = 1'b0;

    // Reset mid-DRAW: the aborted SIMPLE deal must never produce valid.
    deal(3'd1, 1'b0, 8'h00, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_valid", valid, 0);
    chk("abort_cards", cards, 0);
    @(negedge clk);
    reset = 1'b0;

    // SIMPLE script with wrap, then SPLIT / BLACKJACK / DOUBLE pointers independent.
    deal(3'd1, 1'b1, 8'h8A, 3);
    deal(3'd1, 1'b1, 8'h64, 3);
    deal(3'd1, 1'b1, 8'hA4, 3);
    deal(3'd4, 1'b1, 8'hAA, 3);
    deal(3'd4, 1'b1, 8'h89, 3);
    deal(3'd4, 1'b1, 8'h48, 3);
    deal(3'd4, 1'b1, 8'h28, 3);
    deal(3'd4, 1'b1, 8'hAA, 3);
    deal(3'd3, 1'b1, 8'h1A, 3);
    deal(3'd4, 1'b1, 8'h89, 3);
    deal(3'd2, 1'b1, 8'h8A, 3);
    deal(3'd1, 1'b1, 8'h48, 3);
    deal(3'd5, 1'b1, 8'h00, 3);
    deal(3'd7, 1'b1, 8'h00, 3);
    wait_drain();

    // req held for 9 sampling edges: accepts at edges 0, 4, 8 only.
    wait_idle();
    q.push_back('{8'h46, 3, 6'd52});
    q.push_back('{8'h8A, 3, 6'd52});
    q.push_back('{8'h64, 3, 6'd52});
    mode = 3'd1;
    req  = 1'b1;
    repeat (9) @(posedge clk);
    #1 req = 1'b0;
    wait_drain();

    // Extra req pulses during DRAW and DONE are dropped.
    wait_idle();
    q.push_back('{8'hA4, 3, 6'd52});
    req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk);
    #1 req = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 req = 1'b0;
    wait_drain();

    // BASE from reset against the LFSR model.
    reset = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    lf     = 16'hACE1;
    left_m = 52;
    for (int i = 0; i < 16; i++) begin
      cnt[i]  = 4;
      hist[i] = 0;
    end
    base_phase = 1'b1;
    for (int d = 0; d < 1000; d++) begin
`ifdef DECK_TRACK_EN
      if (d == 26) begin
        wait_drain();
        chk("shoe_empty", cards_left, 0);
        for (int v = 1; v <= 10; v++) chk($sformatf("hist_%0d", v), hist[v], (v == 10) ? 16 : 4);
      end
`endif
      base_deal();
    end
    wait_drain();
    base_phase = 1'b0;
    chk("base_card_count", base_cards, 2 * 1000);
    chk("base_card_range", bad, 0);
    chk("base_tens_ratio", (tens >= 540 && tens <= 690), 1);
    chk("queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
